// File: rtl/warblade_pkg.sv
// rtl/warblade_pkg.sv - shared state encoding and defaults for the warblade game blocks
package warblade_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_FLIGHT = 2'd2,
        ST_COOL   = 2'd3
    } state_t;

    localparam int COOLDOWN_DEFAULT = 8;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker starting at a pointer
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             valid,
    output logic [ID_W-1:0]  winner,
    output logic [N_REQ-1:0] onehot
);

    // Scan upward from ptr with wrap; the first set request bit wins.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] pos;
        valid  = 1'b0;
        winner = '0;
        onehot = '0;
        idx    = 0;
        pos    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            pos = ID_W'(idx);
            if (!valid && req[pos]) begin
                valid       = 1'b1;
                winner      = pos;
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/missile_arbiter.sv
// rtl/missile_arbiter.sv - round-robin owner of the enemy missile engine with flight tracking and cooldown
module missile_arbiter
    import warblade_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int COOLDOWN = COOLDOWN_DEFAULT
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    input  logic             missile_busy,
    output logic             launch,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic [7:0]       shots_fired
);

    localparam logic [7:0]      CD_LOAD  = 8'(COOLDOWN);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

    state_t           state, state_n;
    logic             launch_n;
    logic [N_REQ-1:0] grant_n;
    logic [ID_W-1:0]  grant_id_n;
    logic [7:0]       shots_n;
    logic [ID_W-1:0]  ptr, ptr_n;
    logic [7:0]       cd_cnt, cd_n;

    logic             pick_valid;
    logic [ID_W-1:0]  pick_id;
    logic [N_REQ-1:0] pick_onehot;
    logic [ID_W-1:0]  ptr_after_win;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_id),
        .onehot (pick_onehot)
    );

    // Pointer moves one past the registered winner, wrapping at N_REQ.
    always_comb begin
        ptr_after_win = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
    end

    // Next-state and next-output decisions for the missile lifecycle.
    always_comb begin
        state_n    = state;
        launch_n   = 1'b0;
        grant_n    = grant;
        grant_id_n = grant_id;
        shots_n    = shots_fired;
        ptr_n      = ptr;
        cd_n       = cd_cnt;
        case (state)
            ST_IDLE: begin
                // Requests are looked at only here; a stale missile blocks the decision.
                if (enable && pick_valid && !missile_busy) begin
                    grant_n    = pick_onehot;
                    grant_id_n = pick_id;
                    launch_n   = 1'b1;
                    state_n    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                shots_n = shots_fired + 8'd1;
                ptr_n   = ptr_after_win;
                state_n = ST_FLIGHT;
            end
            ST_FLIGHT: begin
                // Busy low ends the flight, including a missile that never took off.
                if (!missile_busy) begin
                    grant_n = '0;
                    if (COOLDOWN == 0) begin
                        state_n = ST_IDLE;
                    end else begin
                        cd_n    = CD_LOAD;
                        state_n = ST_COOL;
                    end
                end
            end
            ST_COOL: begin
                if (frame_tick) begin
                    cd_n = cd_cnt - 8'd1;
                    if (cd_cnt == 8'd1) begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any grant without a launch.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= ST_IDLE;
            launch      <= 1'b0;
            grant       <= '0;
            grant_id    <= '0;
            shots_fired <= 8'd0;
            ptr         <= '0;
            cd_cnt      <= 8'd0;
        end else begin
            state       <= state_n;
            launch      <= launch_n;
            grant       <= grant_n;
            grant_id    <= grant_id_n;
            shots_fired <= shots_n;
            ptr         <= ptr_n;
            cd_cnt      <= cd_n;
        end
    end

endmodule

// File: tb/tb_missile_arbiter.sv
// tb/tb_missile_arbiter.sv - scoreboard bench for missile_arbiter
module tb_missile_arbiter;

    logic       pclk;
    logic       rst;
    logic       frame_tick;
    logic       enable;
    logic [3:0] req;
    logic       missile_busy;
    logic       launch;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic [7:0] shots_fired;

    logic [3:0] req0;
    logic       busy0;
    logic       launch0;
    logic [3:0] grant0;
    logic [1:0] grant_id0;
    logic [7:0] shots0;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int sb_shots = 0;

    typedef struct {
        int id;
        int at;
        int shots;
    } exp_t;

    exp_t q[$];

    int         rr_id   [8] = '{0, 1, 2, 3, 0, 2, 0, 1};
    int         rr_fly  [8] = '{3, 0, 5, 1, 2, 1, 1, 1};
    bit         rr_tend [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] rr_nreq [8] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111,
                                4'b0100, 4'b0011, 4'b0011, 4'b0000};

    missile_arbiter #(
        .N_REQ    (4),
        .ID_W     (2),
        .COOLDOWN (2)
    ) dut (
        .pclk         (pclk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .enable       (enable),
        .req          (req),
        .missile_busy (missile_busy),
        .launch       (launch),
        .grant        (grant),
        .grant_id     (grant_id),
        .shots_fired  (shots_fired)
    );

    missile_arbiter #(
        .N_REQ    (4),
        .ID_W     (2),
        .COOLDOWN (0)
    ) dut0 (
        .pclk         (pclk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .enable       (enable),
        .req          (req0),
        .missile_busy (busy0),
        .launch       (launch0),
        .grant        (grant0),
        .grant_id     (grant_id0),
        .shots_fired  (shots0)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        forever begin
            @(posedge pclk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) step();
    endtask

    task automatic expect_launch(input int id, input int at);
        exp_t e;
        sb_shots = (sb_shots + 1) % 256;
        e.id     = id;
        e.at     = at;
        e.shots  = sb_shots;
        q.push_back(e);
    endtask

    // Called in the launch cycle: plays the engine, then delivers cooldown ticks.
    task automatic fly_cool(input int fly, input int cool, input bit tick_end,
                            input logic [3:0] oh, input logic [3:0] nreq, output int nxt);
        int last;
        last = 0;
        step();
        if (fly > 0) begin
            missile_busy = 1'b1;
            repeat (fly) step();
        end
        missile_busy = 1'b0;
        frame_tick   = tick_end;
        chk("grant_held_in_flight", int'(grant), int'(oh));
        step();
        frame_tick = 1'b0;
        chk("grant_cleared_after_busy", int'(grant), 0);
        if (cool == 0) begin
            nxt = cyc + 1;
        end else begin
            for (int i = 0; i < cool; i++) begin
                step();
                frame_tick = 1'b0;
                step();
                frame_tick = 1'b1;
                last = cyc;
            end
            step();
            frame_tick = 1'b0;
            nxt = last + 2;
        end
        req = nreq;
    endtask

    // Monitor: every launch pulse must match the head of the scoreboard.
    initial begin
        bit   lp;
        bit   sp;
        int   se;
        exp_t e;
        lp = 1'b0;
        sp = 1'b0;
        se = 0;
        forever begin
            @(negedge pclk);
            if (sp) begin
                chk("shots_after_launch", int'(shots_fired), se);
                sp = 1'b0;
            end
            chk("grant_onehot0", int'($onehot0(grant)), 1);
            if (launch) begin
                chk("launch_not_back_to_back", int'(lp), 0);
                chk("launch_was_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("launch_cycle", cyc, e.at);
                    chk("launch_grant_id", int'(grant_id), e.id);
                    chk("launch_grant", int'(grant), 1 << e.id);
                    sp = 1'b1;
                    se = e.shots;
                end
            end
            lp = launch;
        end
    end

    initial begin
        int at;
        rst          = 1'b1;
        frame_tick   = 1'b0;
        enable       = 1'b0;
        missile_busy = 1'b0;
        req          = 4'b0000;
        req0         = 4'b0000;
        busy0        = 1'b0;
        at           = 0;
        repeat (3) step();
        chk("reset_launch", int'(launch), 0);
        chk("reset_grant", int'(grant), 0);
        chk("reset_grant_id", int'(grant_id), 0);
        chk("reset_shots", int'(shots_fired), 0);
        chk("reset_launch0", int'(launch0), 0);
        chk("reset_shots0", int'(shots0), 0);
        rst    = 1'b0;
        enable = 1'b1;
        step();

        // Single requester, long flight, two-tick cooldown.
        req = 4'b0100;
        at  = cyc + 1;
        expect_launch(2, at);
        goto_cycle(at);
        fly_cool(10, 2, 1'b0, 4'b0100, 4'b0000, at);
        repeat (5) step();

        // Round-robin fairness from reset, then wrap and skip.
        rst = 1'b1;
        repeat (2) step();
        rst      = 1'b0;
        sb_shots = 0;
        step();
        req = 4'b1111;
        at  = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            expect_launch(rr_id[i], at);
            goto_cycle(at);
            fly_cool(rr_fly[i], 2, rr_tend[i], 4'(1 << rr_id[i]), rr_nreq[i], at);
        end
        repeat (5) step();

        // Enable low blocks grants; stale busy blocks grants.
        enable = 1'b0;
        req    = 4'b1111;
        repeat (100) step();
        missile_busy = 1'b1;
        enable       = 1'b1;
        repeat (20) step();
        missile_busy = 1'b0;
        at = cyc + 1;
        expect_launch(2, at);
        goto_cycle(at);
        fly_cool(3, 2, 1'b0, 4'b0100, 4'b0000, at);
        repeat (3) step();

        // Reset in flight drops everything at once.
        req = 4'b0001;
        at  = cyc + 1;
        expect_launch(0, at);
        goto_cycle(at);
        step();
        missile_busy = 1'b1;
        step();
        rst = 1'b1;
        step();
        chk("rst_flight_grant", int'(grant), 0);
        chk("rst_flight_launch", int'(launch), 0);
        chk("rst_flight_grant_id", int'(grant_id), 0);
        chk("rst_flight_shots", int'(shots_fired), 0);
        rst          = 1'b0;
        missile_busy = 1'b0;
        req          = 4'b0000;
        sb_shots     = 0;
        repeat (3) step();

        // 256 launches wrap the shot counter back to zero.
        req = 4'b0001;
        at  = cyc + 1;
        for (int n = 0; n < 256; n++) begin
            expect_launch(0, at);
            goto_cycle(at);
            fly_cool(1, 2, 1'b0, 4'b0001, (n == 255) ? 4'b0000 : 4'b0001, at);
        end
        repeat (3) step();
        chk("shots_wrapped_to_zero", int'(shots_fired), sb_shots);

        // Zero cooldown: relaunch two cycles after busy falls.
        chk("cd0_idle_launch", int'(launch0), 0);
        chk("cd0_idle_shots", int'(shots0), 0);
        req0 = 4'b0010;
        step();
        chk("cd0_launch", int'(launch0), 1);
        chk("cd0_grant_id", int'(grant_id0), 1);
        chk("cd0_grant", int'(grant0), 2);
        step();
        busy0 = 1'b1;
        chk("cd0_launch_low", int'(launch0), 0);
        step();
        busy0 = 1'b0;
        step();
        chk("cd0_grant_clear", int'(grant0), 0);
        chk("cd0_no_launch_yet", int'(launch0), 0);
        step();
        chk("cd0_relaunch", int'(launch0), 1);
        chk("cd0_relaunch_id", int'(grant_id0), 1);
        req0 = 4'b0000;
        step();
        chk("cd0_shots", int'(shots0), 2);
        chk("cd0_relaunch_pulse_low", int'(launch0), 0);

        repeat (5) step();
        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
